// File: rtl/hazard_flush_unit.sv
// hazard_flush_unit
// Pipeline hazard controller beside the decode stage. It detects load-use
// hazards between the decode instruction and the load held in the
// decode/execute buffer, and taken branches resolved in execute. It drives
// the PC/fetch stall, the decode/execute bubble, the fetch/decode flush and
// the 2-bit flush count consumed by the decode/execute buffer.
//
// Optional feature macro: HAZARD_STALL_CNT_EN
//   defined   -> a 16-bit saturating stall-cycle counter is built
//   undefined -> no counter, stall_count is tied to 0

module hazard_flush_unit #(
  parameter int FLUSH_DEPTH = 2,
  parameter int MEM_WAIT    = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [2:0]  dec_src1,
  input  logic [2:0]  dec_src2,
  input  logic        dec_use1,
  input  logic        dec_use2,
  input  logic        de_mr,
  input  logic        de_rw,
  input  logic [2:0]  de_dst,
  input  logic        branch_taken,
  output logic        pc_stall,
  output logic        fd_stall,
  output logic        fd_flush,
  output logic        de_bubble,
  output logic [1:0]  flush_num,
  output logic        busy,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // The first cycle of a stall or flush is produced combinationally from
  // IDLE, so the registered counter only has to cover the remaining cycles.
  localparam logic [1:0] FlushNum    = 2'(FLUSH_DEPTH);
  localparam logic [1:0] FlushReload = 2'(FLUSH_DEPTH - 1);
  localparam logic [1:0] StallReload = 2'(MEM_WAIT - 1);
  localparam bit         FlushMulti  = (FLUSH_DEPTH > 1);
  localparam bit         StallMulti  = (MEM_WAIT > 1);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       srcMatch1, srcMatch2;
  logic       loadUse;

  // A load in decode/execute whose destination is read by the decode
  // instruction cannot forward in time, so decode must wait.
  always_comb begin
    srcMatch1 = dec_use1 && (dec_src1 == de_dst);
    srcMatch2 = dec_use2 && (dec_src2 == de_dst);
    loadUse   = de_mr && de_rw && (srcMatch1 || srcMatch2);
  end

  // Next-state and output decode; a taken branch beats any stall or flush
  // in progress, which in turn beats a fresh load-use hazard.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_stall  = 1'b0;
    fd_stall  = 1'b0;
    fd_flush  = 1'b0;
    de_bubble = 1'b0;
    flush_num = 2'd0;

    if (branch_taken) begin
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
      flush_num = FlushNum;
      if (FlushMulti) begin
        state_d = FLUSH;
        cnt_d   = FlushReload;
      end else begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    end else begin
      case (state_q)
        STALL: begin
          pc_stall  = 1'b1;
          fd_stall  = 1'b1;
          de_bubble = 1'b1;
          if (cnt_q <= 2'd1) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
          end else begin
            cnt_d   = cnt_q - 2'd1;
          end
        end
        FLUSH: begin
          fd_flush  = 1'b1;
          de_bubble = 1'b1;
          flush_num = cnt_q;
          if (cnt_q <= 2'd1) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
          end else begin
            cnt_d   = cnt_q - 2'd1;
          end
        end
        default: begin
          if (loadUse) begin
            pc_stall  = 1'b1;
            fd_stall  = 1'b1;
            de_bubble = 1'b1;
            if (StallMulti) begin
              state_d = STALL;
              cnt_d   = StallReload;
            end else begin
              state_d = IDLE;
              cnt_d   = 2'd0;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = 2'd0;
          end
        end
      endcase
    end
  end

  // State and remaining-cycle counter, cleared synchronously.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);

`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stallCount_q, stallCount_d;

  // Count every cycle the PC is held, sticking at all-ones instead of wrapping.
  always_comb begin
    stallCount_d = stallCount_q;
    if (pc_stall && (stallCount_q != 16'hFFFF)) begin
      stallCount_d = stallCount_q + 16'd1;
    end
  end

  // Performance counter register, cleared with the rest of the unit.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stallCount_q <= 16'd0;
    end else begin
      stallCount_q <= stallCount_d;
    end
  end

  assign stall_count = stallCount_q;
`else
  assign stall_count = 16'd0;
`endif

endmodule
